pipe_stall_ctrl: RTL

//  Parametrised stall/flush controller for the in-order pipeline; successor to the fixed 5-stage stall unit.

---
 rtl/pipe_stall_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the in-order pipeline.
// Turns D-cache miss, branch flush, load-use and I-cache miss events into
// per-register stall/flush vectors. It also tracks how long a miss has lasted,
// locks up after a miss timeout, and keeps a saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int NREG         = 5,
    parameter int LU_IDX       = 2,
    parameter int BR_IDX       = 2,
    parameter int DM_IDX       = 3,
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_ICache_Miss,
    input  logic             i_DCache_Miss,
    input  logic             i_LoadUse,
    input  logic             i_BranchFlush,
    input  logic             i_Cnt_Clr,
    output logic [NREG-1:0]  o_Stall,
    output logic [NREG-1:0]  o_Flush,
    output logic [1:0]       o_State,
    output logic             o_Timeout,
    output logic [CNT_W-1:0] o_Stall_Cnt
);

    localparam int MW = $clog2(MISS_TIMEOUT + 1);

    localparam logic [1:0]    ST_RUN   = 2'b00;
    localparam logic [1:0]    ST_IMISS = 2'b01;
    localparam logic [1:0]    ST_DMISS = 2'b10;
    localparam logic [1:0]    ST_LOCK  = 2'b11;
    localparam logic [MW-1:0] MCNT_ONE = MW'(1);
    localparam logic [MW-1:0] MCNT_TO  = MW'(MISS_TIMEOUT);

    logic [1:0]       state_r;
    logic [1:0]       nxt_state_s;
    logic [1:0]       cand_state_s;
    logic [MW-1:0]    mcnt_r;
    logic [MW-1:0]    mcnt_nxt_s;
    logic             timeout_r;
    logic [CNT_W-1:0] scnt_r;
    logic [NREG-1:0]  stall_s;
    logic [NREG-1:0]  flush_s;

    // State register together with the consecutive-miss counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_RUN;
            mcnt_r  <= '0;
        end else begin
            state_r <= nxt_state_s;
            mcnt_r  <= mcnt_nxt_s;
        end
    end

    // Next state: LOCK is absorbing. A miss that persists too long forces LOCK.
    always_comb begin
        cand_state_s = ST_RUN;
        nxt_state_s  = state_r;
        mcnt_nxt_s   = mcnt_r;
        case (state_r)
            ST_LOCK: begin
                nxt_state_s = ST_LOCK;
                mcnt_nxt_s  = mcnt_r;
            end
            default: begin
                if (i_DCache_Miss) begin
                    cand_state_s = ST_DMISS;
                end else if (i_ICache_Miss) begin
                    cand_state_s = ST_IMISS;
                end else begin
                    cand_state_s = ST_RUN;
                end
                // The count restarts whenever the miss kind changes or the miss drops
                if (cand_state_s == ST_RUN) begin
                    mcnt_nxt_s = '0;
                end else if (cand_state_s == state_r) begin
                    mcnt_nxt_s = mcnt_r + MCNT_ONE;
                end else begin
                    mcnt_nxt_s = MCNT_ONE;
                end
                if ((cand_state_s != ST_RUN) && (mcnt_nxt_s >= MCNT_TO)) begin
                    nxt_state_s = ST_LOCK;
                end else begin
                    nxt_state_s = cand_state_s;
                end
            end
        endcase
    end

    // Output vectors: only the highest-priority event drives them; flush beats stall
    always_comb begin
        stall_s = '0;
        flush_s = '0;
        if (Rst) begin
            flush_s = '1;
        end else if (state_r == ST_LOCK) begin
            stall_s = '1;
        end else if (i_DCache_Miss) begin
            for (int k = 0; k < NREG; k++) begin
                if (k <= DM_IDX) stall_s[k] = 1'b1;
                if (k == DM_IDX + 1) flush_s[k] = 1'b1;
            end
        end else if (i_BranchFlush) begin
            for (int k = 0; k < NREG; k++) begin
                if ((k >= 1) && (k <= BR_IDX)) flush_s[k] = 1'b1;
            end
        end else if (i_LoadUse) begin
            for (int k = 0; k < NREG; k++) begin
                if (k < LU_IDX) stall_s[k] = 1'b1;
                if (k == LU_IDX) flush_s[k] = 1'b1;
            end
        end else if (i_ICache_Miss) begin
            for (int k = 0; k < NREG; k++) begin
                if (k == 0) stall_s[k] = 1'b1;
                if (k == 1) flush_s[k] = 1'b1;
            end
        end else begin
            stall_s = '0;
            flush_s = '0;
        end
        stall_s = stall_s & ~flush_s;
    end

    // Sticky lock-up flag, set on the edge that enters LOCK
    always_ff @(posedge Clk) begin
        if (Rst) begin
            timeout_r <= 1'b0;
        end else if (nxt_state_s == ST_LOCK) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    // Saturating count of stalled cycles; a clear beats an increment
    always_ff @(posedge Clk) begin
        if (Rst) begin
            scnt_r <= '0;
        end else if (i_Cnt_Clr) begin
            scnt_r <= '0;
        end else if ((|stall_s) && (scnt_r != {CNT_W{1'b1}})) begin
            scnt_r <= scnt_r + CNT_W'(1);
        end else begin
            scnt_r <= scnt_r;
        end
    end

    assign o_Stall     = stall_s;
    assign o_Flush     = flush_s;
    assign o_State     = state_r;
    assign o_Timeout   = timeout_r;
    assign o_Stall_Cnt = scnt_r;

endmodule
